// File: rtl/sd_spi_master.sv
// SPI mode-0 master for the microSD card path: power-up dummy clocks with CS high,
// then full-duplex DATA_W-bit MSB-first transfers over a valid/ready word handshake.
`timescale 1ns / 1ps
module sd_spi_master #(
   parameter int DATA_W    = 8,
   parameter int DIV_SLOW  = 125,
   parameter int DIV_FAST  = 2,
   parameter int INIT_CLKS = 80
) (
   input  logic              CLK50,
   input  logic              RST,
   input  logic              FAST,
   input  logic              CS_ASSERT,
   input  logic              INIT_REQ,
   input  logic              TX_VALID,
   input  logic [DATA_W-1:0] TX_DATA,
   output logic              TX_READY,
   output logic              RX_VALID,
   output logic [DATA_W-1:0] RX_DATA,
   output logic              INIT_DONE,
   output logic              SCLK,
   output logic              MOSI,
   input  logic              MISO,
   output logic              CS
);

   localparam int HP_W = $clog2(DIV_SLOW + 1);
   localparam int BC_W = $clog2(DATA_W + 1);
   localparam int EC_W = $clog2(INIT_CLKS + 1);

   localparam logic [HP_W-1:0] HP_ONE    = HP_W'(1);
   localparam logic [HP_W-1:0] SLOW_LAST = HP_W'(DIV_SLOW - 1);
   localparam logic [HP_W-1:0] FAST_LAST = HP_W'(DIV_FAST - 1);
   localparam logic [BC_W-1:0] BIT_ONE   = BC_W'(1);
   localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_W - 1);
   localparam logic [EC_W-1:0] EDGE_ONE  = EC_W'(1);
   localparam logic [EC_W-1:0] EDGE_ALL  = EC_W'(INIT_CLKS);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_XFER} state_t;

   state_t            state;
   logic [DATA_W-1:0] shifter;
   logic [HP_W-1:0]   hp_last;   // half-period length minus one, latched per word
   logic [HP_W-1:0]   hp_cnt;
   logic [BC_W-1:0]   bit_cnt;
   logic [EC_W-1:0]   edge_cnt;
   logic              hp_done;
   logic              init_end;

   assign hp_done  = (hp_cnt == hp_last);
   assign init_end = (edge_cnt == EDGE_ALL) && !SCLK;

   // NOTE: every flop, shifter included, takes a reset value; there is no memory array here.
   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         state     <= ST_INIT;
         SCLK      <= 1'b0;
         MOSI      <= 1'b1;
         CS        <= 1'b1;
         TX_READY  <= 1'b0;
         RX_VALID  <= 1'b0;
         RX_DATA   <= '0;
         INIT_DONE <= 1'b0;
         shifter   <= '0;
         hp_last   <= SLOW_LAST;
         hp_cnt    <= '0;
         bit_cnt   <= '0;
         edge_cnt  <= '0;
      end else begin
         // NOTE: non-blocking throughout, so every branch decides on pre-edge values.
         RX_VALID <= 1'b0;
         case (state)
            ST_INIT: begin
               CS       <= 1'b1;
               MOSI     <= 1'b1;
               TX_READY <= init_end;
               if (init_end) begin
                  INIT_DONE <= 1'b1;
                  state     <= ST_IDLE;
               end else if (hp_done) begin
                  hp_cnt <= '0;
                  SCLK   <= ~SCLK;
                  if (!SCLK) edge_cnt <= edge_cnt + EDGE_ONE;
               end else begin
                  hp_cnt <= hp_cnt + HP_ONE;
               end
            end

            ST_IDLE: begin
               SCLK <= 1'b0;
               MOSI <= 1'b1;
               CS   <= ~CS_ASSERT;
               if (INIT_REQ) begin
                  // Rerun always wins over a word offered in the same cycle.
                  state     <= ST_INIT;
                  INIT_DONE <= 1'b0;
                  TX_READY  <= 1'b0;
                  CS        <= 1'b1;
                  hp_last   <= SLOW_LAST;
                  hp_cnt    <= '0;
                  edge_cnt  <= '0;
               end else if (TX_VALID && TX_READY) begin
                  shifter  <= TX_DATA;
                  hp_last  <= FAST ? FAST_LAST : SLOW_LAST;
                  MOSI     <= TX_DATA[DATA_W-1];
                  TX_READY <= 1'b0;
                  hp_cnt   <= '0;
                  bit_cnt  <= '0;
                  state    <= ST_XFER;
               end
            end

            ST_XFER: begin
               if (!hp_done) begin
                  hp_cnt <= hp_cnt + HP_ONE;
               end else begin
                  hp_cnt <= '0;
                  SCLK   <= ~SCLK;
                  if (!SCLK) begin
                     // Shifting left exposes the next TX bit at the MSB for the coming fall.
                     shifter <= {shifter[DATA_W-2:0], MISO};
                  end else if (bit_cnt == BIT_LAST) begin
                     RX_DATA  <= shifter;
                     RX_VALID <= 1'b1;
                     TX_READY <= 1'b1;
                     MOSI     <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     MOSI    <= shifter[DATA_W-1];
                     bit_cnt <= bit_cnt + BIT_ONE;
                  end
               end
            end

            default: state <= ST_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_spi_master.sv
// Self-checking bench for sd_spi_master: directed vector table, hand-written corner
// sequences and random words checked against a card-side shift model.
`timescale 1ns / 1ps
module tb_sd_spi_master;

   localparam int DATA_W    = 8;
   localparam int DIV_SLOW  = 125;
   localparam int DIV_FAST  = 2;
   localparam int INIT_CLKS = 80;

   logic              CLK50 = 1'b0;
   logic              RST = 1'b0;
   logic              FAST = 1'b0;
   logic              CS_ASSERT = 1'b0;
   logic              INIT_REQ = 1'b0;
   logic              TX_VALID = 1'b0;
   logic [DATA_W-1:0] TX_DATA = '0;
   logic              TX_READY;
   logic              RX_VALID;
   logic [DATA_W-1:0] RX_DATA;
   logic              INIT_DONE;
   logic              SCLK;
   logic              MOSI;
   logic              MISO;
   logic              CS;

   int checks = 0;
   int failures = 0;

   int                cyc = 0;
   int                fall_cnt = 0;
   int                rise_cnt = 0;
   int                rxv_cnt = 0;
   logic [DATA_W-1:0] mosi_sr = '0;

   // Card model: shifts slave_word out MSB first, moving to the next bit on each SCLK fall.
   logic              loopback = 1'b0;
   logic [DATA_W-1:0] slave_word = '0;
   int                slave_base = 0;
   int                sidx;
   logic              slave_bit;

   always_comb begin
      sidx      = fall_cnt - slave_base;
      slave_bit = 1'b1;
      if (sidx >= 0 && sidx < DATA_W) slave_bit = slave_word[DATA_W-1-sidx];
   end

   assign MISO = loopback ? MOSI : slave_bit;

   sd_spi_master #(
      .DATA_W   (DATA_W),
      .DIV_SLOW (DIV_SLOW),
      .DIV_FAST (DIV_FAST),
      .INIT_CLKS(INIT_CLKS)
   ) dut (
      .CLK50    (CLK50),
      .RST      (RST),
      .FAST     (FAST),
      .CS_ASSERT(CS_ASSERT),
      .INIT_REQ (INIT_REQ),
      .TX_VALID (TX_VALID),
      .TX_DATA  (TX_DATA),
      .TX_READY (TX_READY),
      .RX_VALID (RX_VALID),
      .RX_DATA  (RX_DATA),
      .INIT_DONE(INIT_DONE),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .CS       (CS)
   );

   always #10 CLK50 = ~CLK50;

   always @(posedge CLK50) cyc <= cyc + 1;
   always @(negedge SCLK) fall_cnt <= fall_cnt + 1;
   always @(posedge SCLK) begin
      rise_cnt <= rise_cnt + 1;
      mosi_sr  <= {mosi_sr[DATA_W-2:0], MOSI};
   end
   always @(negedge CLK50) if (RX_VALID === 1'b1) rxv_cnt <= rxv_cnt + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int exp_latency(input logic fast);
      return 2 * DATA_W * (fast ? DIV_FAST : DIV_SLOW);
   endfunction

   // Follows one dummy-clock sequence from its start until INIT_DONE, checking its shape.
   task automatic watch_init(input string tag);
      int   n, rises, first_r, first_f, last_r, last_f, bad;
      logic prev;
      n = 0; rises = 0; first_r = -1; first_f = -1; last_r = -1; last_f = -1; bad = 0;
      prev = SCLK;
      while (INIT_DONE !== 1'b1 && n < 2 * DIV_SLOW * (INIT_CLKS + 2)) begin
         @(negedge CLK50);
         n++;
         if (CS !== 1'b1 || MOSI !== 1'b1) bad++;
         if (TX_READY !== INIT_DONE) bad++;
         if (SCLK && !prev) begin
            rises++;
            if (first_r < 0) first_r = cyc;
            last_r = cyc;
         end
         if (!SCLK && prev) begin
            if (first_f < 0) first_f = cyc;
            last_f = cyc;
         end
         prev = SCLK;
      end
      check({tag, " init_done reached"}, INIT_DONE, 1);
      check({tag, " dummy clock count"}, rises, INIT_CLKS);
      check({tag, " sclk high half-period"}, first_f - first_r, DIV_SLOW);
      check({tag, " first-to-last rise span"}, last_r - first_r, 2 * DIV_SLOW * (INIT_CLKS - 1));
      check({tag, " done one cycle after last fall"}, cyc - last_f, 1);
      check({tag, " cs/mosi high, ready low during init"}, bad, 0);
      check({tag, " tx_ready at done"}, TX_READY, 1);
   endtask

   // One word from handshake to RX_VALID; optionally jiggles FAST/CS_ASSERT mid-word.
   task automatic do_xfer(input logic fast, input logic cs_a, input logic lb,
                          input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] sw,
                          input bit jitter,
                          output logic [DATA_W-1:0] rx, output int lat,
                          output logic [DATA_W-1:0] mo, output int rises, output int cs_bad);
      int n, t_acc, r0;
      rx = '0; lat = -1; mo = '0; rises = 0; cs_bad = 0;
      n = 0;
      while (TX_READY !== 1'b1 && n < 200) begin
         @(negedge CLK50);
         n++;
      end
      check("tx_ready before accept", TX_READY, 1);
      loopback   = lb;
      slave_word = sw;
      slave_base = fall_cnt;
      r0         = rise_cnt;
      FAST       = fast;
      CS_ASSERT  = cs_a;
      TX_DATA    = tx;
      TX_VALID   = 1'b1;
      t_acc      = cyc + 1;
      @(negedge CLK50);
      TX_VALID = 1'b0;
      n = 0;
      while (RX_VALID !== 1'b1 && n < 2 * DIV_SLOW * DATA_W + 20) begin
         if (CS !== ~cs_a) cs_bad++;
         if (jitter) begin
            FAST      = 1'($urandom_range(0, 1));
            CS_ASSERT = 1'($urandom_range(0, 1));
         end
         @(negedge CLK50);
         n++;
      end
      FAST      = fast;
      CS_ASSERT = cs_a;
      if (RX_VALID === 1'b1) begin
         lat = cyc - t_acc;
         rx  = RX_DATA;
      end
      mo    = mosi_sr;
      rises = rise_cnt - r0;
   endtask

   typedef struct {
      logic              fast;
      logic              cs_a;
      logic              loop;
      logic [DATA_W-1:0] tx;
      logic [DATA_W-1:0] sw;
      logic [DATA_W-1:0] exp_rx;
      int                exp_lat;
   } vec_t;

   initial begin
      vec_t              vecs[4];
      logic [DATA_W-1:0] rx, mo, rxd[2], exp_rx, exp_mo;
      int                lat, rises, cs_bad, n, rxc[2], nrx, acc2, fall_c, gap, r0, rxv0;
      logic              prev_s, drop_next, fast, cs_a;
      bit                jitter;

      vecs[0] = '{1'b1, 1'b1, 1'b1, 8'h40, 8'h00, 8'h40, 32};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hA5, 8'hA5, 2000};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 32};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 8'hC3, 8'h00, 8'hC3, 32};

      // Reset values, then the power-up dummy-clock sequence.
      #3 RST = 1'b1;
      repeat (3) @(negedge CLK50);
      check("reset {sclk,mosi,cs,ready,rx_valid,init_done}",
            {SCLK, MOSI, CS, TX_READY, RX_VALID, INIT_DONE}, 6'b011000);
      check("reset rx_data", RX_DATA, 0);
      RST = 1'b0;
      watch_init("t1");

      foreach (vecs[i]) begin
         do_xfer(vecs[i].fast, vecs[i].cs_a, vecs[i].loop, vecs[i].tx, vecs[i].sw, 1'b0,
                 rx, lat, mo, rises, cs_bad);
         check($sformatf("vec%0d rx_data", i), rx, vecs[i].exp_rx);
         check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d mosi bits", i), mo, vecs[i].tx);
         check($sformatf("vec%0d sclk rises", i), rises, DATA_W);
         check($sformatf("vec%0d cs held", i), cs_bad, 0);
      end

      // Back-to-back with TX_VALID held: the second accept closes the first RX_VALID cycle.
      n = 0;
      while (TX_READY !== 1'b1 && n < 200) begin
         @(negedge CLK50);
         n++;
      end
      loopback = 1'b1; FAST = 1'b1; CS_ASSERT = 1'b1; TX_DATA = 8'h12; TX_VALID = 1'b1;
      @(negedge CLK50);
      TX_DATA = 8'h34;
      nrx = 0; acc2 = -1; fall_c = -1; gap = -1; cs_bad = 0; n = 0;
      rxd[0] = '0; rxd[1] = '0; rxc[0] = 0; rxc[1] = 0;
      prev_s = SCLK; drop_next = 1'b0;
      while (nrx < 2 && n < 200) begin
         if (drop_next) begin
            TX_VALID  = 1'b0;
            drop_next = 1'b0;
         end
         if (CS !== 1'b0) cs_bad++;
         if (prev_s && !SCLK) fall_c = cyc;
         if (!prev_s && SCLK && nrx == 1 && gap < 0) gap = cyc - fall_c;
         prev_s = SCLK;
         if (RX_VALID === 1'b1) begin
            rxd[nrx] = RX_DATA;
            rxc[nrx] = cyc;
            nrx++;
         end
         if (TX_VALID && TX_READY === 1'b1 && nrx == 1 && acc2 < 0) begin
            acc2      = cyc + 1;
            drop_next = 1'b1;
         end
         @(negedge CLK50);
         n++;
      end
      TX_VALID = 1'b0;
      check("t4 rx_valid pulses", nrx, 2);
      check("t4 first word", rxd[0], 8'h12);
      check("t4 second word", rxd[1], 8'h34);
      check("t4 accept in rx_valid cycle", acc2 - rxc[0], 1);
      check("t4 second latency", rxc[1] - acc2, exp_latency(1'b1));
      check("t4 sclk low gap >= div", gap >= DIV_FAST, 1);
      check("t4 cs steady", cs_bad, 0);

      // Random words against the card model; some have FAST/CS_ASSERT wiggled mid-word.
      for (int i = 0; i < 16; i++) begin
         fast   = ($urandom_range(0, 9) != 0);
         cs_a   = 1'($urandom_range(0, 1));
         jitter = 1'($urandom_range(0, 1));
         exp_mo = 8'($urandom);
         exp_rx = 8'($urandom);
         do_xfer(fast, cs_a, 1'b0, exp_mo, exp_rx, jitter, rx, lat, mo, rises, cs_bad);
         check($sformatf("rand%0d rx_data", i), rx, exp_rx);
         check($sformatf("rand%0d latency", i), lat, exp_latency(fast));
         check($sformatf("rand%0d mosi bits", i), mo, exp_mo);
         check($sformatf("rand%0d cs held", i), cs_bad, 0);
      end

      // Reset in the middle of a word.
      n = 0;
      while (TX_READY !== 1'b1 && n < 200) begin
         @(negedge CLK50);
         n++;
      end
      loopback = 1'b1; FAST = 1'b1; CS_ASSERT = 1'b1; TX_DATA = 8'hC3; TX_VALID = 1'b1;
      r0 = rise_cnt;
      @(negedge CLK50);
      TX_VALID = 1'b0;
      n = 0;
      while (rise_cnt - r0 < 4 && n < 200) begin
         @(negedge CLK50);
         n++;
      end
      check("t5 reached bit 4", rise_cnt - r0, 4);
      rxv0 = rxv_cnt;
      RST = 1'b1;
      #1;
      check("t5 outputs in reset", {SCLK, MOSI, CS, TX_READY, RX_VALID, INIT_DONE}, 6'b011000);
      check("t5 rx_data in reset", RX_DATA, 0);
      repeat (2) @(negedge CLK50);
      RST = 1'b0;
      watch_init("t5");
      check("t5 no rx_valid", rxv_cnt - rxv0, 0);

      // INIT_REQ and TX_VALID together: rerun first, then the held word goes out.
      n = 0;
      while (TX_READY !== 1'b1 && n < 200) begin
         @(negedge CLK50);
         n++;
      end
      rxv0 = rxv_cnt;
      loopback = 1'b1; FAST = 1'b1; TX_DATA = 8'h5A; TX_VALID = 1'b1; INIT_REQ = 1'b1;
      @(negedge CLK50);
      INIT_REQ = 1'b0;
      check("t6 init_done cleared", INIT_DONE, 0);
      check("t6 tx_ready dropped", TX_READY, 0);
      watch_init("t6");
      check("t6 no rx during init", rxv_cnt - rxv0, 0);
      do_xfer(1'b1, 1'b1, 1'b1, 8'h5A, 8'h00, 1'b0, rx, lat, mo, rises, cs_bad);
      check("t6 held word rx_data", rx, 8'h5A);
      check("t6 held word latency", lat, exp_latency(1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
